// File: rtl/game_input_ctrl.sv
// game_input_ctrl: push-button front end for the game core.
//   - Synchronizes and debounces four raw buttons (left, right, pause, reset).
//   - Produces mutually exclusive left/right movement levels.
//   - Runs a RUN/PAUSED/OVER freeze FSM driven by pause presses and game_over.
//   - Emits a one-cycle reset_game pulse on a debounced reset press and at power-up.
//   - Generates a free-running one-cycle movement tick (clk50).
//
// Ports:
//   clk, rst_n                  clock (rising edge), async active-low reset
//   btn_left/right/pause/reset  raw asynchronous buttons, active-high
//   game_over                   level from collision logic
//   left, right                 debounced movement levels
//   pause                       game-freeze level (high in PAUSED and OVER)
//   reset_game                  one-cycle restart pulse
//   clk50                       one-cycle movement tick enable
//
// All outputs are decoded from flops only; no input reaches an output combinationally.
module game_input_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TICK_DIV        = 2000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_pause,
    input  logic btn_reset,
    input  logic game_over,
    output logic left,
    output logic right,
    output logic pause,
    output logic reset_game,
    output logic clk50
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    // Button lane indices
    localparam int unsigned BtnLeft  = 0;
    localparam int unsigned BtnRight = 1;
    localparam int unsigned BtnPause = 2;
    localparam int unsigned BtnReset = 3;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StPaused = 2'd1,
        StOver   = 2'd2
    } state_e;

    logic [3:0]      btn_raw;
    logic [3:0]      sync1_q;
    logic [3:0]      sync2_q;
    logic [3:0]      db_q;
    logic [DB_W-1:0] cnt_q [4];

    logic            pause_prev_q;
    logic            reset_prev_q;
    logic            pause_edge;
    logic            reset_edge;
    logic            reset_game_q;

    state_e          state_q;
    state_e          state_d;

    logic [TICK_W-1:0] tick_q;

    assign btn_raw = {btn_reset, btn_pause, btn_right, btn_left};

    // Synchronizer + debounce. The counter tracks how long the synchronized
    // value has disagreed with the accepted state; any agreement restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            for (int i = 0; i < 4; i++) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (cnt_q[i] == DB_LAST) begin
                        db_q[i]  <= sync2_q[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + DB_W'(1);
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    // Previous-value flops for rising-edge detection, and the restart pulse.
    // reset_game resets high so release of rst_n yields a power-up restart pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_prev_q <= 1'b0;
            reset_prev_q <= 1'b0;
            reset_game_q <= 1'b1;
        end else begin
            pause_prev_q <= db_q[BtnPause];
            reset_prev_q <= db_q[BtnReset];
            reset_game_q <= reset_edge;
        end
    end

    assign pause_edge = db_q[BtnPause] & ~pause_prev_q;
    assign reset_edge = db_q[BtnReset] & ~reset_prev_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a reset press overrides everything else.
    always_comb begin
        state_d = state_q;
        if (reset_edge) begin
            state_d = StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (game_over) begin
                        state_d = StOver;
                    end else if (pause_edge) begin
                        state_d = StPaused;
                    end
                end
                StPaused: begin
                    if (game_over) begin
                        state_d = StOver;
                    end else if (pause_edge) begin
                        state_d = StRun;
                    end
                end
                StOver: begin
                    state_d = StOver;
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

    // FSM outputs
    always_comb begin
        pause = 1'b0;
        if (state_q != StRun) begin
            pause = 1'b1;
        end
    end

    // Free-running movement tick; unaffected by pause or reset_game.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= '0;
        end else if (tick_q == TICK_LAST) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + TICK_W'(1);
        end
    end

    assign clk50      = (tick_q == TICK_LAST);
    assign reset_game = reset_game_q;

    // Opposing directions cancel out.
    assign left  = db_q[BtnLeft] & ~db_q[BtnRight];
    assign right = db_q[BtnRight] & ~db_q[BtnLeft];

endmodule

// File: tb/tb_game_input_ctrl.sv
module tb_game_input_ctrl;

    logic clk;
    logic rst_n;
    logic btn_left;
    logic btn_right;
    logic btn_pause;
    logic btn_reset;
    logic game_over;
    logic left;
    logic right;
    logic pause;
    logic reset_game;
    logic clk50;

    int n_checks;
    int n_pass;

    game_input_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .TICK_DIV       (5)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_pause (btn_pause),
        .btn_reset (btn_reset),
        .game_over (game_over),
        .left      (left),
        .right     (right),
        .pause     (pause),
        .reset_game(reset_game),
        .clk50     (clk50)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_pause = 1'b0;
        btn_reset = 1'b0;
        game_over = 1'b0;

        // Reset values
        step(3);
        check("rst_left", 32'(left), 32'd0);
        check("rst_right", 32'(right), 32'd0);
        check("rst_pause", 32'(pause), 32'd0);
        check("rst_clk50", 32'(clk50), 32'd0);
        check("rst_reset_game", 32'(reset_game), 32'd1);

        // Release; power-up pulse ends at first edge, tick at 4, 9
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (k == 1) check("pwrup_reset_game", 32'(reset_game), 32'd0);
            check($sformatf("tick_k%0d", k), 32'(clk50), 32'((k % 5) == 4));
        end

        // Clean left press: visible 6 cycles later
        btn_left = 1'b1;
        step(5);
        check("left_c5", 32'(left), 32'd0);
        step(1);
        check("left_c6", 32'(left), 32'd1);
        btn_left = 1'b0;
        step(5);
        check("left_rel_c5", 32'(left), 32'd1);
        step(1);
        check("left_rel_c6", 32'(left), 32'd0);
        step(4);

        // 3-cycle glitch is rejected
        btn_left = 1'b1;
        step(3);
        btn_left = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            check($sformatf("glitch_k%0d", k), 32'(left), 32'd0);
        end

        // Both held cancel; releasing right gives left six cycles later
        btn_left  = 1'b1;
        btn_right = 1'b1;
        step(8);
        check("both_left", 32'(left), 32'd0);
        check("both_right", 32'(right), 32'd0);
        btn_right = 1'b0;
        step(5);
        check("relr_c5_left", 32'(left), 32'd0);
        step(1);
        check("relr_c6_left", 32'(left), 32'd1);
        check("relr_c6_right", 32'(right), 32'd0);
        btn_left = 1'b0;
        step(8);

        // Pause toggles one cycle after debounced edge
        btn_pause = 1'b1;
        step(6);
        check("p1_c6", 32'(pause), 32'd0);
        step(1);
        check("p1_c7", 32'(pause), 32'd1);
        btn_pause = 1'b0;
        step(8);
        check("p1_hold", 32'(pause), 32'd1);
        btn_pause = 1'b1;
        step(6);
        check("p2_c6", 32'(pause), 32'd1);
        step(1);
        check("p2_c7", 32'(pause), 32'd0);
        btn_pause = 1'b0;
        step(8);

        // game_over -> OVER; pause presses ignored
        game_over = 1'b1;
        step(1);
        check("over_pause", 32'(pause), 32'd1);
        game_over = 1'b0;
        btn_pause = 1'b1;
        step(10);
        check("over_press", 32'(pause), 32'd1);
        btn_pause = 1'b0;
        step(8);
        check("over_release", 32'(pause), 32'd1);

        // Reset press exits OVER with a single reset_game cycle
        btn_reset = 1'b1;
        step(6);
        check("rg_c6_pulse", 32'(reset_game), 32'd0);
        check("rg_c6_pause", 32'(pause), 32'd1);
        step(1);
        check("rg_c7_pulse", 32'(reset_game), 32'd1);
        check("rg_c7_pause", 32'(pause), 32'd0);
        step(1);
        check("rg_c8_pulse", 32'(reset_game), 32'd0);
        check("rg_c8_pause", 32'(pause), 32'd0);
        btn_reset = 1'b0;
        step(8);

        // Simultaneous pause and reset edges from RUN: reset wins
        btn_pause = 1'b1;
        btn_reset = 1'b1;
        step(7);
        check("sim_c7_pause", 32'(pause), 32'd0);
        check("sim_c7_pulse", 32'(reset_game), 32'd1);
        step(1);
        check("sim_c8_pause", 32'(pause), 32'd0);
        btn_pause = 1'b0;
        btn_reset = 1'b0;
        step(8);

        // Mid-operation reset: left established, paused, right mid-debounce
        btn_left  = 1'b1;
        btn_pause = 1'b1;
        step(8);
        check("pre_left", 32'(left), 32'd1);
        check("pre_pause", 32'(pause), 32'd1);
        btn_right = 1'b1;
        step(3);
        rst_n = 1'b0;
        #2;
        check("mid_left", 32'(left), 32'd0);
        check("mid_right", 32'(right), 32'd0);
        check("mid_pause", 32'(pause), 32'd0);
        check("mid_clk50", 32'(clk50), 32'd0);
        check("mid_reset_game", 32'(reset_game), 32'd1);
        btn_right = 1'b0;
        btn_pause = 1'b0;
        step(2);
        rst_n = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (k == 1) check("mid_pwrup_pulse", 32'(reset_game), 32'd0);
            if (k == 5) check("mid_left_c5", 32'(left), 32'd0);
            if (k == 6) check("mid_left_c6", 32'(left), 32'd1);
            check($sformatf("mid_tick_k%0d", k), 32'(clk50), 32'((k % 5) == 4));
        end
        btn_left = 1'b0;
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/game_input_ctrl.md
GAME_INPUT_CTRL -- requirements
Module: game_input_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, meaning the consecutive stable cycles required to accept a button change (10 ms at 100 MHz).
REQ-002 SHALL have parameter TICK_DIV, default 2000000, meaning the clk cycles per movement tick (50 Hz at 100 MHz).
REQ-003 SHALL have port clk  input  1  system clock (100 MHz); every register is clocked on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have ports btn_left, btn_right, btn_pause, btn_reset  input  1 each  raw asynchronous push-buttons, active-high.
REQ-006 SHALL have port game_over  input  1  level from the collision logic; high means the game has ended.
REQ-007 SHALL have ports left, right  output  1 each  debounced movement levels for the sprite mover.
REQ-008 SHALL have port pause  output  1  game-freeze level.
REQ-009 SHALL have port reset_game  output  1  synchronous game-restart pulse.
REQ-010 SHALL have port clk50  output  1  one-cycle movement tick enable.

Function
REQ-011 SHALL pass each button through a 2-flop synchronizer before any other logic.
REQ-012 SHALL keep, per button, a debounced state and a counter sized ceil(log2(DEBOUNCE_CYCLES+1)) bits.
REQ-013 SHALL increment a button's counter each cycle its synchronized value differs from its debounced state, and clear the counter whenever the two are equal.
REQ-014 SHALL update a button's debounced state and clear its counter on the cycle the counter reaches DEBOUNCE_CYCLES-1 while the difference persists.
REQ-015 SHALL therefore make a debounced change visible DEBOUNCE_CYCLES+2 cycles after a clean input edge; a glitch shorter than DEBOUNCE_CYCLES SHALL produce no change.
REQ-016 SHALL drive left = db_left AND NOT db_right, and right = db_right AND NOT db_left, so that both pressed gives left=0, right=0.
REQ-017 SHALL detect the rising edge of db_pause (current 1, previous 0) as pause_edge, and of db_reset as reset_edge, using registered previous-value flops.
REQ-018 SHALL register pause and implement it as a 3-state FSM:
  - RUN (pause=0): pause_edge -> PAUSED; game_over=1 -> OVER.
  - PAUSED (pause=1): pause_edge -> RUN, unless game_over=1, which -> OVER.
  - OVER (pause=1): pause_edge is ignored; exit only via reset_edge.
REQ-019 SHALL force the FSM to RUN on reset_edge from any state, with priority over pause_edge and game_over in the same cycle.
REQ-020 SHALL register reset_game and assert it for exactly one cycle, the cycle after reset_edge.
REQ-021 SHALL run a free-running tick counter 0..TICK_DIV-1 that wraps to 0.
REQ-022 SHALL assert clk50 for one cycle when the tick counter equals TICK_DIV-1; reset_game and pause SHALL NOT affect the tick counter.
REQ-023 SHALL produce no combinational path from any input to any output.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously clear all synchronizer flops, debounced states, edge flops, debounce counters and the tick counter to 0.
REQ-025 SHALL, while rst_n=0, drive left=0, right=0, pause=0 (FSM=RUN), clk50=0 and reset_game=1.
REQ-026 SHALL deassert reset_game on the first rising clk edge after rst_n goes high, giving a power-up restart pulse.
REQ-027 SHALL return to the state of REQ-024/025 immediately if rst_n is asserted mid-operation, including mid-debounce or mid-tick.

Verification (DEBOUNCE_CYCLES=4, TICK_DIV=5)
REQ-028 SHALL verify: btn_left rises at cycle 0 and is held -> left=1 at cycle 6; a 3-cycle btn_left glitch -> left stays 0.
REQ-029 SHALL verify: btn_left and btn_right both held -> left=0, right=0; btn_right released -> left=1 six cycles after the release.
REQ-030 SHALL verify: two clean btn_pause presses -> pause 0->1->0, with each change one cycle after its debounced edge; with game_over=1 -> pause=1 and further presses are ignored.
REQ-031 SHALL verify: in OVER, a btn_reset press -> reset_game high for exactly 1 cycle, pause=0 on the same cycle; debounced pause and reset edges in the same cycle -> pause=0.
REQ-032 SHALL verify: after rst_n release -> reset_game=1 for 1 cycle, then clk50 pulses at cycles 4, 9, 14, ... (period 5, width 1).
REQ-033 SHALL verify: rst_n pulsed low mid-debounce and mid-tick -> all outputs at reset values at once; debounce restarts from count 0 and the clk50 phase restarts from count 0.
